rom_port_arbiter: RTL and testbench

//  Shares one read port of the word ROM between an instruction-fetch requester (I) and a data-load requester (D).
//  Per-requester req/gnt handshake; one-cycle registered response; up to one grant per cycle.

---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_arb_pick.sv | 33 +++
 rtl/rom_port_arbiter.sv | 66 ++++++
 tb/tb_rom_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and state types for the ROM read-port arbiter.
package rom_arb_pkg;

    localparam logic [1:0] ARB_NONE = 2'd0;
    localparam logic [1:0] ARB_I    = 2'd1;
    localparam logic [1:0] ARB_D    = 2'd2;

    localparam int unsigned RSP_LATENCY = 1;

    typedef enum logic {
        WIN_I = 1'b0,
        WIN_D = 1'b1
    } winner_e;

    typedef enum logic [1:0] {
        RSP_NONE = ARB_NONE,
        RSP_I    = ARB_I,
        RSP_D    = ARB_D
    } rsp_owner_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational two-way picker for the ROM arbiter.
// ROM_ARB_RR_EN selects round-robin; otherwise D has fixed priority.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  winner_e last_winner,
    output logic    gnt_i,
    output logic    gnt_d
);

    always_comb begin
        gnt_i = req_i;
        gnt_d = req_d;
        if (req_i && req_d) begin
`ifdef ROM_ARB_RR_EN
            gnt_i = (last_winner == WIN_D);
            gnt_d = (last_winner == WIN_I);
`else
            // Loads win conflicts so a stalled pipeline unblocks first.
            gnt_i = 1'b0;
            gnt_d = 1'b1;
`endif
        end
    end

`ifndef ROM_ARB_RR_EN
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one async ROM read port between instruction fetch (I) and data load (D).
// Arbitration policy set by ROM_ARB_RR_EN (round-robin) or fixed D priority when undefined.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_rdata
);

    winner_e    last_winner;
    rsp_owner_e rsp_owner;
    logic       req_i_live;
    logic       req_d_live;

    assign req_i_live = i_req & ~rst;
    assign req_d_live = d_req & ~rst;

    rom_arb_pick u_pick (
        .req_i       (req_i_live),
        .req_d       (req_d_live),
        .last_winner (last_winner),
        .gnt_i       (i_gnt),
        .gnt_d       (d_gnt)
    );

    assign rom_addr = d_gnt ? d_addr : i_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= WIN_D;
            rsp_owner   <= RSP_NONE;
            i_rdata     <= '0;
            d_rdata     <= '0;
        end else begin
            rsp_owner <= RSP_NONE;
            if (i_gnt) begin
                rsp_owner   <= RSP_I;
                i_rdata     <= rom_rdata;
                last_winner <= WIN_I;
            end else if (d_gnt) begin
                rsp_owner   <= RSP_D;
                d_rdata     <= rom_rdata;
                last_winner <= WIN_D;
            end
        end
    end

    // rst masks rvalid immediately so a response pending across reset is dropped.
    assign i_rvalid = (rsp_owner == RSP_I) && !rst;
    assign d_rvalid = (rsp_owner == RSP_D) && !rst;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; follows ROM_ARB_RR_EN like the RTL.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [11:0] i_addr, d_addr;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [11:0] rom_addr;
    logic [31:0] rom_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // ROM model: word at 0x010 is 0xDEADBEEF, elsewhere 0xA5000000 | addr.
    assign rom_rdata = (rom_addr == 12'h010) ? 32'hDEADBEEF : {20'hA5000, rom_addr};

    rom_port_arbiter #(.ADDR_WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 12'h010;
        d_addr = 12'h020;

        // 1: reset held with both requests pending
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_i_gnt", i_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_i_rvalid", i_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
            check("rst_i_rdata", i_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            @(posedge clk);
        end
        @(negedge clk);
        rst   = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        check("idle_rom_addr", rom_addr, 12'h010);

        // 2: solo I
        i_req = 1'b1;
        #1;
        check("solo_i_gnt", i_gnt, 1);
        check("solo_d_gnt", d_gnt, 0);
        check("solo_rom_addr", rom_addr, 12'h010);
        @(negedge clk);
        check("solo_i_rvalid", i_rvalid, 1);
        check("solo_i_rdata", i_rdata, 32'hDEADBEEF);
        check("solo_d_rvalid", d_rvalid, 0);
        check("solo_d_rdata", d_rdata, 0);
        i_req = 1'b0;
        @(negedge clk);
        check("solo_i_rvalid_drop", i_rvalid, 0);
        check("solo_i_rdata_hold", i_rdata, 32'hDEADBEEF);

`ifdef ROM_ARB_RR_EN
        // 3: round-robin conflict right after reset, I wins first
        do_reset();
        i_addr = 12'h100;
        d_addr = 12'h200;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_i_gnt", i_gnt, (k % 2 == 0) ? 1 : 0);
            check("rr_d_gnt", d_gnt, (k % 2 == 1) ? 1 : 0);
            @(negedge clk);
            check("rr_i_rvalid", i_rvalid, (k % 2 == 0) ? 1 : 0);
            check("rr_d_rvalid", d_rvalid, (k % 2 == 1) ? 1 : 0);
        end
        check("rr_i_rdata", i_rdata, 32'hA5000100);
        check("rr_d_rdata", d_rdata, 32'hA5000200);
        i_req = 1'b0;
        d_req = 1'b0;
`else
        // 4: fixed priority conflict, D wins, I follows once D drops
        do_reset();
        i_addr = 12'h100;
        d_addr = 12'h200;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fx_i_gnt", i_gnt, 0);
            check("fx_d_gnt", d_gnt, 1);
            check("fx_rom_addr", rom_addr, 12'h200);
            @(negedge clk);
            check("fx_d_rvalid", d_rvalid, 1);
            check("fx_i_rvalid", i_rvalid, 0);
        end
        check("fx_d_rdata", d_rdata, 32'hA5000200);
        d_req = 1'b0;
        #1;
        check("fx_i_gnt_after", i_gnt, 1);
        check("fx_rom_addr_after", rom_addr, 12'h100);
        @(negedge clk);
        check("fx_i_rvalid_after", i_rvalid, 1);
        check("fx_i_rdata_after", i_rdata, 32'hA5000100);
        i_req = 1'b0;
`endif

        // 5: streaming I requests, one per cycle
        @(negedge clk);
        i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 12'(4 * k);
            #1;
            check("strm_i_gnt", i_gnt, 1);
            @(negedge clk);
            check("strm_i_rvalid", i_rvalid, 1);
            check("strm_i_rdata", i_rdata, 32'hA5000000 + 32'(4 * k));
        end
        i_req = 1'b0;
        @(negedge clk);
        check("strm_i_rvalid_end", i_rvalid, 0);

        // 6: reset arrives the cycle after a D grant
        d_addr = 12'h040;
        d_req  = 1'b1;
        #1;
        check("mid_d_gnt", d_gnt, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_d_gnt_rst", d_gnt, 0);
        check("mid_d_rvalid_n1", d_rvalid, 0);
        @(negedge clk);
        check("mid_d_rvalid_n1b", d_rvalid, 0);
        @(negedge clk);
        check("mid_d_rvalid_n2", d_rvalid, 0);
        check("mid_d_rdata", d_rdata, 0);
        check("mid_i_rdata", i_rdata, 0);
        rst   = 1'b0;
        d_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
